// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit
//   Avalon-MM load/store master between the multicycle CPU MEM stage and the
//   memory bus. It takes one sized request (byte/half/word/dword, signed or
//   unsigned loads), checks alignment, and runs one bus cycle with the correct
//   byteenable and lane steering. It waits out waitrequest, then returns a
//   single-cycle response.
//
//   Parameters: DATA_W (32 or 64), ADDR_W, TIMEOUT_CYCLES.
//   Build option: define MEM_TIMEOUT_EN to abort a stalled bus cycle after
//   TIMEOUT_CYCLES waitrequest cycles with resp_err=1. Without it the unit
//   waits indefinitely.
//
//   Ports:
//     clk, rst_n                   clock / async active-low reset
//     req_valid/ready/write/size/signed/addr/wdata   CPU request
//     resp_valid/rdata/err         CPU response (one-cycle pulse)
//     address/read/write/waitrequest/writedata/byteenable/readdata  Avalon-MM
//
//   state  | meaning
//   S_IDLE | ready for a request; alignment check on accept
//   S_BUS  | Avalon read/write asserted, waiting for waitrequest=0
//   S_RESP | resp_valid pulse, rdata/err presented
module mips_mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int LSB  = $clog2(BE_W);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter: loaded on entry to BUS, one tick per stall cycle; the
    // last permitted stall cycle is the one that sees a count of 1.
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic [LSB-1:0]      off;
    logic [LSB+2:0]      shamt;
    logic                bus_act;
    logic                misaligned;
    logic [BE_W-1:0]     be_base;
    logic [DATA_W-1:0]   sh, lmask, load_ext;
    logic                sbit;

    assign off   = addr_q[LSB-1:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = (DATA_W == 32) || (|req_addr[2:0]);
            default: misaligned = 1'b0;
        endcase
    end

    // Load path: move the addressed lane down to bit 0, keep only the access
    // width, then fill the upper bits with the sign bit when requested.
    always_comb begin
        sh      = readdata >> shamt;
        lmask   = '1;
        sbit    = sh[DATA_W-1];
        be_base = '1;
        case (size_q)
            2'd0: begin lmask = DATA_W'(8'hFF);         sbit = sh[7];  be_base = BE_W'(1);    end
            2'd1: begin lmask = DATA_W'(16'hFFFF);      sbit = sh[15]; be_base = BE_W'(2'h3); end
            2'd2: begin lmask = DATA_W'(32'hFFFF_FFFF); sbit = sh[31]; be_base = BE_W'(4'hF); end
            default: begin lmask = '1; sbit = sh[DATA_W-1]; be_base = '1; end
        endcase
        load_ext = (sh & lmask) | ((signed_q && sbit) ? ~lmask : '0);
    end

    assign bus_act    = (state_q == S_BUS);
    assign read       = bus_act && !wr_q;
    assign write      = bus_act && wr_q;
    assign address    = bus_act ? (addr_q & ~ADDR_W'(BE_W - 1)) : '0;
    assign byteenable = bus_act ? (be_base << off) : '0;
    assign writedata  = bus_act ? (wdata_q << shamt) : '0;
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d     = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
`ifdef MEM_TIMEOUT_EN
                    cnt_d    = CNT_W'(TIMEOUT_CYCLES);
`endif
                    if (misaligned) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (!waitrequest) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : load_ext;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
